// File: rtl/neuron_layer_ctrl_if.sv
// ---------------------------------------------------------------------------
// neuron_layer_ctrl_if
// Groups the three valid/ready streams of neuron_layer_ctrl into one bundle.
//
// Signals (W = sample/weight width):
//   cfg_valid / cfg_ready / cfg_data[W]       weight stream, row-major order
//   in_valid  / in_ready  / in_data[W]        input-sample stream
//   out_valid / out_ready / out_data[W]       neuron-result stream
//   out_last                                  marks the final neuron result
//
// Modports:
//   master : the environment (weight source, sample source, result sink)
//   slave  : the layer controller
// ---------------------------------------------------------------------------
interface neuron_layer_ctrl_if #(
    parameter int W = 16
) ();
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_data;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;

    modport master (
        output cfg_valid, cfg_data, in_valid, in_data, out_ready,
        input  cfg_ready, in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  cfg_valid, cfg_data, in_valid, in_data, out_ready,
        output cfg_ready, in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/neuron_layer_ctrl.sv
// ---------------------------------------------------------------------------
// neuron_layer_ctrl
// Sequencer for one fully-connected layer of Q(FIXED_BITS.FRACTIONAL_BITS)
// neurons sharing a single multiply-accumulate unit. Loads a weight matrix
// from the cfg stream, buffers one input vector, then computes and emits each
// neuron result in order, one MAC term per cycle.
//
// Ports:
//   i_clk     rising-edge clock
//   i_rst     synchronous active-high reset
//   i_reload  return to weight loading (honoured only in IN with no samples)
//   o_loaded  a complete weight matrix is held
//   bus       neuron_layer_ctrl_if.slave: cfg, in and out streams
//
// Build option:
//   NEURON_CTRL_SAT_EN  defined   -> out_data saturates acc to W-bit range
//                       undefined -> out_data = acc[W-1:0] (wraps)
// ---------------------------------------------------------------------------
module neuron_layer_ctrl #(
    parameter int FIXED_BITS      = 8,
    parameter int FRACTIONAL_BITS = 8,
    parameter int NUM_INPUTS      = 4,
    parameter int NUM_NEURONS     = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_reload,
    output logic               o_loaded,
    neuron_layer_ctrl_if.slave bus
);
    localparam int W           = FIXED_BITS + FRACTIONAL_BITS;
    localparam int AW          = 2 * W;
    localparam int NUM_WEIGHTS = NUM_INPUTS * NUM_NEURONS;
    localparam int WA_BITS     = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1;
    localparam int I_BITS      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int N_BITS      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    localparam logic [WA_BITS-1:0] LAST_W = WA_BITS'(NUM_WEIGHTS - 1);
    localparam logic [I_BITS-1:0]  LAST_I = I_BITS'(NUM_INPUTS - 1);
    localparam logic [N_BITS-1:0]  LAST_N = N_BITS'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_IN,
        S_MAC,
        S_EMIT
    } state_t;

    state_t               r_state;
    logic [WA_BITS-1:0]   r_waddr;    // weight write address in LOAD, read pointer in MAC
    logic [I_BITS-1:0]    r_i;        // sample slot in IN, term index in MAC
    logic [N_BITS-1:0]    r_n;
    logic signed [AW-1:0] r_acc;
    logic                 r_loaded;
    logic                 r_out_valid;
    logic [W-1:0]         r_out_data;
    logic                 r_out_last;

    logic [W-1:0] r_weight [NUM_WEIGHTS];
    logic [W-1:0] r_sample [NUM_INPUTS];

    logic                 w_reload_take;
    logic                 w_in_ready;
    logic                 w_cfg_fire;
    logic                 w_in_fire;
    logic [W-1:0]         w_x;
    logic [W-1:0]         w_w;
    logic signed [AW-1:0] w_x_ext;
    logic signed [AW-1:0] w_w_ext;
    logic signed [AW-1:0] w_prod;
    logic signed [AW-1:0] w_term;
    logic signed [AW-1:0] w_acc_next;
    logic [W-1:0]         w_result;

    // Reload is only legal before the first sample of a vector. When it
    // coincides with in_valid, in_ready is pulled low that same cycle so the
    // sample stays with the source; this is the one input-to-ready path.
    assign w_reload_take = i_reload && (r_state == S_IN) && (r_i == '0);
    assign w_in_ready    = (r_state == S_IN) && !w_reload_take;
    assign w_cfg_fire    = bus.cfg_valid && (r_state == S_LOAD);
    assign w_in_fire     = bus.in_valid && w_in_ready;

    assign bus.cfg_ready = (r_state == S_LOAD);
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign o_loaded      = r_loaded;

    // MAC datapath: full 2W signed product, arithmetic shift back to Q format.
    assign w_x        = r_sample[r_i];
    assign w_w        = r_weight[r_waddr];
    assign w_x_ext    = {{W{w_x[W-1]}}, w_x};
    assign w_w_ext    = {{W{w_w[W-1]}}, w_w};
    assign w_prod     = w_x_ext * w_w_ext;
    assign w_term     = w_prod >>> FRACTIONAL_BITS;
    assign w_acc_next = r_acc + w_term;

`ifdef NEURON_CTRL_SAT_EN
    localparam logic signed [AW-1:0] SAT_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};
`endif

    // Output formatting from the final accumulator value; only the emitted
    // value is clamped, the accumulator itself always keeps full precision.
    always_comb begin
        // NOTE: assign a default before any condition so every path drives
        // w_result; a missing branch would otherwise infer a latch.
        w_result = w_acc_next[W-1:0];
`ifdef NEURON_CTRL_SAT_EN
        if (w_acc_next > SAT_MAX) begin
            w_result = {1'b0, {(W-1){1'b1}}};
        end else if (w_acc_next < SAT_MIN) begin
            w_result = {1'b1, {(W-1){1'b0}}};
        end
`endif
    end

    // NOTE: weight and sample storage carries no reset; every entry is
    // written before it is read, and skipping the reset keeps them RAM-mappable.
    always_ff @(posedge i_clk) begin
        if (w_cfg_fire) begin
            r_weight[r_waddr] <= bus.cfg_data;
        end
        if (w_in_fire) begin
            r_sample[r_i] <= bus.in_data;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order in this block.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_LOAD;
            r_waddr     <= '0;
            r_i         <= '0;
            r_n         <= '0;
            r_acc       <= '0;
            r_loaded    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_cfg_fire) begin
                        if (r_waddr == LAST_W) begin
                            r_waddr  <= '0;
                            r_loaded <= 1'b1;
                            r_state  <= S_IN;
                        end else begin
                            r_waddr <= r_waddr + WA_BITS'(1);
                        end
                    end
                end

                S_IN: begin
                    if (w_reload_take) begin
                        r_waddr  <= '0;
                        r_loaded <= 1'b0;
                        r_state  <= S_LOAD;
                    end else if (w_in_fire) begin
                        if (r_i == LAST_I) begin
                            r_i     <= '0;
                            r_n     <= '0;
                            r_acc   <= '0;
                            r_waddr <= '0;
                            r_state <= S_MAC;
                        end else begin
                            r_i <= r_i + I_BITS'(1);
                        end
                    end
                end

                S_MAC: begin
                    // Row-major storage lets the read pointer simply walk
                    // through the matrix across all neurons of a vector.
                    r_waddr <= (r_waddr == LAST_W) ? '0 : r_waddr + WA_BITS'(1);
                    r_acc   <= w_acc_next;
                    if (r_i == LAST_I) begin
                        r_i         <= '0;
                        r_out_data  <= w_result;
                        r_out_last  <= (r_n == LAST_N);
                        r_out_valid <= 1'b1;
                        r_state     <= S_EMIT;
                    end else begin
                        r_i <= r_i + I_BITS'(1);
                    end
                end

                S_EMIT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_out_last) begin
                            r_state <= S_IN;
                        end else begin
                            r_n     <= r_n + N_BITS'(1);
                            r_acc   <= '0;
                            r_state <= S_MAC;
                        end
                    end
                end

                default: r_state <= S_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_layer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_neuron_layer_ctrl
// Self-checking bench for neuron_layer_ctrl with NUM_INPUTS=2, NUM_NEURONS=2,
// Q8.8. Expected neuron results come from a reference model and are queued
// when a vector is driven, then popped and compared as results are emitted.
// Honours NEURON_CTRL_SAT_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_neuron_layer_ctrl;
    localparam int FB = 8;
    localparam int FR = 8;
    localparam int NI = 2;
    localparam int NN = 2;
    localparam int W  = FB + FR;

    typedef logic [W-1:0] vec_t [NI];
    typedef logic [W-1:0] mat_t [NI*NN];
    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic reload;
    logic loaded;

    neuron_layer_ctrl_if #(.W(W)) bus ();

    neuron_layer_ctrl #(
        .FIXED_BITS     (FB),
        .FRACTIONAL_BITS(FR),
        .NUM_INPUTS     (NI),
        .NUM_NEURONS    (NN)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_reload(reload),
        .o_loaded(loaded),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    mat_t mw;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: acc = sum(floor(x*w / 2^FR)), then wrap or saturate to W bits.
    function automatic logic [W-1:0] model(input int n, input vec_t x);
        longint      acc = 0;
        longint      p;
        logic [63:0] raw;
        for (int i = 0; i < NI; i++) begin
            p = longint'($signed(x[i])) * longint'($signed(mw[n*NI+i]));
            acc += p >>> FR;
        end
`ifdef NEURON_CTRL_SAT_EN
        if (acc > 32767) return 16'h7FFF;
        if (acc < -32768) return 16'h8000;
`endif
        raw = acc;
        return raw[W-1:0];
    endfunction

    task automatic push_expected(input vec_t x);
        exp_t e;
        for (int n = 0; n < NN; n++) begin
            e.data = model(n, x);
            e.last = (n == NN - 1);
            sb.push_back(e);
        end
    endtask

    task automatic load_matrix(input mat_t m);
        int k = 0;
        int guard = 0;
        mw = m;
        while (k < NI*NN && guard < 400) begin
            @(negedge clk);
            bus.cfg_valid = 1'($urandom_range(0, 1));
            bus.cfg_data  = m[k];
            #1;
            if (bus.cfg_valid && bus.cfg_ready) begin
                if (k == NI*NN - 1) begin
                    n_checks++;
                    if (loaded !== 1'b0) begin
                        n_errors++;
                        $display("FAIL loaded_early: got %b want 0", loaded);
                    end
                end
                k++;
            end
            guard++;
        end
        n_checks++;
        if (k != NI*NN) begin
            n_errors++;
            $display("FAIL load_timeout: accepted %0d want %0d", k, NI*NN);
        end
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        #1;
        n_checks++;
        if (loaded !== 1'b1 || bus.in_ready !== 1'b1 || bus.cfg_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL load_done: loaded=%b in_ready=%b cfg_ready=%b want 1 1 0",
                     loaded, bus.in_ready, bus.cfg_ready);
        end
    endtask

    // Presents one sample; returns at the negedge before the accepting edge.
    task automatic drive_sample(input logic [W-1:0] d);
        int guard = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        #1;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) begin
            n_checks++;
            n_errors++;
            $display("FAIL in_timeout: in_ready never rose for sample %h", d);
        end
    endtask

    task automatic drive_vector(input vec_t x);
        push_expected(x);
        for (int i = 0; i < NI; i++) drive_sample(x[i]);
    endtask

    // Collects NN results right after the last sample is presented, checking
    // latency, data, last flag, optional stall stability and in_ready return.
    task automatic collect(input int stall);
        exp_t         e;
        logic [W-1:0] hold_d;
        logic         hold_l;
        int           cycles;
        for (int r = 0; r < NN; r++) begin
            cycles = 0;
            do begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                cycles++;
            end while (!bus.out_valid && cycles < 30);
            n_checks++;
            if (cycles != NI + 1) begin
                n_errors++;
                $display("FAIL latency[%0d]: got %0d cycles want %0d", r, cycles, NI + 1);
            end
            if (r == 0 && stall > 0) begin
                hold_d        = bus.out_data;
                hold_l        = bus.out_last;
                bus.out_ready = 1'b0;
                bus.in_valid  = 1'b1;
                bus.in_data   = 16'h1234;
                repeat (stall) begin
                    @(negedge clk);
                    #1;
                    n_checks++;
                    if (bus.out_valid !== 1'b1 || bus.out_data !== hold_d ||
                        bus.out_last !== hold_l || bus.in_ready !== 1'b0) begin
                        n_errors++;
                        $display("FAIL stall: valid=%b data=%h last=%b in_ready=%b want 1 %h %b 0",
                                 bus.out_valid, bus.out_data, bus.out_last, bus.in_ready,
                                 hold_d, hold_l);
                    end
                end
                bus.in_valid = 1'b0;
            end
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL scoreboard_empty: got result %h with nothing expected", bus.out_data);
            end else begin
                e = sb.pop_front();
                if (bus.out_data !== e.data || bus.out_last !== e.last) begin
                    n_errors++;
                    $display("FAIL result[%0d]: got data=%h last=%b want data=%h last=%b",
                             r, bus.out_data, bus.out_last, e.data, e.last);
                end
            end
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL after_vector: in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload       = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0500;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reload_in_ready: got %b want 0", bus.in_ready);
        end
        @(negedge clk);
        reload       = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if (loaded !== 1'b0 || bus.cfg_ready !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reload_state: loaded=%b cfg_ready=%b in_ready=%b want 0 1 0",
                     loaded, bus.cfg_ready, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        reload        = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.cfg_ready !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.out_data !== 16'h0000 || bus.out_last !== 1'b0 || loaded !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: cfg_ready=%b in_ready=%b out_valid=%b out_data=%h out_last=%b loaded=%b want 1 0 0 0000 0 0",
                     bus.cfg_ready, bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, loaded);
        end
    endtask

    task automatic test_weight_load();
        load_matrix('{16'h0100, 16'h0080, 16'hFF00, 16'h0200});
    endtask

    task automatic test_functional();
        drive_vector('{16'h0300, 16'h0100});
        collect(0);
    endtask

    task automatic test_back_to_back();
        vec_t x;
        drive_vector('{16'hFE80, 16'h0040});
        collect(0);
        drive_vector('{16'h0003, 16'hFFFF});
        collect(0);
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < NI; i++) x[i] = 16'($urandom);
            drive_vector(x);
            collect(0);
        end
    endtask

    task automatic test_backpressure();
        drive_vector('{16'h0200, 16'hFF80});
        collect(5);
    endtask

    task automatic test_reload_ignored();
        push_expected('{16'h0100, 16'hFF00});
        drive_sample(16'h0100);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reload       = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reload_ignored_ready: got %b want 1", bus.in_ready);
        end
        @(negedge clk);
        reload = 1'b0;
        #1;
        n_checks++;
        if (loaded !== 1'b1 || bus.cfg_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reload_ignored_state: loaded=%b cfg_ready=%b want 1 0", loaded, bus.cfg_ready);
        end
        drive_sample(16'hFF00);
        collect(0);
    endtask

    task automatic test_reload();
        do_reload();
        load_matrix('{16'h0200, 16'hFF80, 16'h0040, 16'h0100});
        drive_vector('{16'h0180, 16'hFD00});
        collect(0);
    endtask

    task automatic test_saturation();
        do_reload();
        load_matrix('{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF});
        drive_vector('{16'h7FFF, 16'h7FFF});
        collect(0);
    endtask

    task automatic test_reset_mid_mac();
        drive_vector('{16'h0300, 16'h0100});
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.cfg_ready !== 1'b1 || bus.out_valid !== 1'b0 || loaded !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_mac: cfg_ready=%b out_valid=%b loaded=%b in_ready=%b want 1 0 0 0",
                     bus.cfg_ready, bus.out_valid, loaded, bus.in_ready);
        end
        sb.delete();
        load_matrix('{16'h0100, 16'h0080, 16'hFF00, 16'h0200});
        drive_vector('{16'hFF00, 16'h0280});
        collect(0);
    endtask

    initial begin
        test_reset();
        test_weight_load();
        test_functional();
        test_back_to_back();
        test_backpressure();
        test_reload_ignored();
        test_reload();
        test_saturation();
        test_reset_mid_mac();
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_leftover: %0d results never emitted", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
